bus_cycle_ctrl: RTL and testbench

//  Bus cycle sequencer downstream of the address ALU and upstream of the instruction queue.
//  - Runs 8088-style T1-T2-T3-(Tw)*-T4 memory cycles on the external bus.
//  - Issues a cycle for either an execution-unit operand request or an instruction-prefetch byte.
//  - Pushes each prefetched byte into the queue and increments IP.
//  - Drives the direction control of the in/out buffer.

---
 rtl/bus_cycle_ctrl_pkg.sv | 14 +
 rtl/wait_timer.sv | 31 +++
 rtl/bus_cycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cycle_ctrl_pkg.sv
// rtl/bus_cycle_ctrl_pkg.sv - state encoding and shared constants for the bus cycle sequencer
package bus_defs;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_TW   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;

  localparam logic KIND_EU = 1'b0;
  localparam logic KIND_PF = 1'b1;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;
endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - counts wait states of one bus cycle and flags the last permitted one
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(WAIT_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // High during the WAIT_MAX-th Tw: if ready is still low the cycle must end now.
  assign expired = inc && (cnt_q == CW'(WAIT_MAX - 1));
endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - T1-T2-T3-Tw-T4 bus sequencer for EU operand and prefetch cycles
module bus_cycle_ctrl
  import bus_defs::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eu_req,
  input  logic              eu_wr,
  input  logic [ADDR_W-1:0] eu_addr,
  input  logic [DATA_W-1:0] eu_wdata,
  output logic              eu_ack,
  output logic [DATA_W-1:0] eu_rdata,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic              q_full,
  input  logic              flush,
  output logic              q_push,
  output logic [DATA_W-1:0] q_data,
  output logic              ip_inc,
  output logic              ale,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              bus_err
);
  logic [2:0]        state_q, state_d;
  logic              kind_q, kind_d;
  logic              wr_q, wr_d;
  logic              flush_seen_q, flush_seen_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] eu_rdata_q, eu_rdata_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;

  logic              expired, eu_go, pf_go, in_t4, strobe, cap_en;
  logic [DATA_W-1:0] cap_val;

  wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_T1),
    .inc     (state_q == ST_TW),
    .expired (expired)
  );

  always_comb begin
    in_t4 = (state_q == ST_T4);
    // The request being acknowledged in this T4 is still held; it must not start a second cycle.
    eu_go = eu_req && !(in_t4 && (kind_q == KIND_EU));
    pf_go = !q_full && !flush;

    state_d      = state_q;
    kind_d       = kind_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    flush_seen_d = flush_seen_q;
    timeout_d    = timeout_q;
    eu_rdata_d   = eu_rdata_q;
    q_data_d     = q_data_q;
    cap_en       = 1'b0;
    cap_val      = din;

    case (state_q)
      ST_IDLE, ST_T4: begin
        flush_seen_d = 1'b0;
        timeout_d    = 1'b0;
        if (eu_go) begin
          state_d = ST_T1;
          kind_d  = KIND_EU;
          wr_d    = eu_wr;
          addr_d  = eu_addr;
          wdata_d = eu_wdata;
        end else if (pf_go) begin
          state_d = ST_T1;
          kind_d  = KIND_PF;
          wr_d    = 1'b0;
          addr_d  = pf_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T1: begin
        state_d      = ST_T2;
        flush_seen_d = flush_seen_q | flush;
      end
      ST_T2: begin
        state_d      = ST_T3;
        flush_seen_d = flush_seen_q | flush;
      end
      ST_T3: begin
        flush_seen_d = flush_seen_q | flush;
        if (ready) begin
          state_d = ST_T4;
          cap_en  = 1'b1;
        end else begin
          state_d = ST_TW;
        end
      end
      ST_TW: begin
        flush_seen_d = flush_seen_q | flush;
        if (ready) begin
          state_d = ST_T4;
          cap_en  = 1'b1;
        end else if (expired) begin
          state_d   = ST_T4;
          cap_en    = 1'b1;
          cap_val   = DATA_W'(BUS_IDLE_DATA);
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cap_en && !wr_q) begin
      if (kind_q == KIND_EU) eu_rdata_d = cap_val;
      else                   q_data_d   = cap_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_EU;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      flush_seen_q <= 1'b0;
      timeout_q    <= 1'b0;
      eu_rdata_q   <= '0;
      q_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      flush_seen_q <= flush_seen_d;
      timeout_q    <= timeout_d;
      eu_rdata_q   <= eu_rdata_d;
      q_data_q     <= q_data_d;
    end
  end

  assign strobe   = (state_q == ST_T2) || (state_q == ST_T3) || (state_q == ST_TW);
  assign ale      = (state_q == ST_T1);
  assign addr_out = addr_q;
  assign rd_n     = !(strobe && !wr_q);
  assign wr_n     = !(strobe && wr_q);
  assign dout_en  = wr_q && (strobe || in_t4);
  assign dout     = dout_en ? wdata_q : '0;
  assign eu_ack   = in_t4 && (kind_q == KIND_EU);
  // A flush arriving in T4 itself still drops the byte, hence the live flush term.
  assign q_push   = in_t4 && (kind_q == KIND_PF) && !wr_q && !flush_seen_q && !flush;
  assign ip_inc   = q_push;
  assign bus_err  = in_t4 && timeout_q;
  assign eu_rdata = eu_rdata_q;
  assign q_data   = q_data_q;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 8;
  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        eu_req = 1'b0, eu_wr = 1'b0;
  logic [19:0] eu_addr = '0, pf_addr = '0;
  logic [7:0]  eu_wdata = '0, din = '0;
  logic        q_full = 1'b1, flush = 1'b0, ready = 1'b1;
  logic        eu_ack, q_push, ip_inc, ale, rd_n, wr_n, dout_en, bus_err;
  logic [7:0]  eu_rdata, q_data, dout;
  logic [19:0] addr_out;

  always #5 clk = ~clk;

  bus_cycle_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .eu_req(eu_req), .eu_wr(eu_wr), .eu_addr(eu_addr),
    .eu_wdata(eu_wdata), .eu_ack(eu_ack), .eu_rdata(eu_rdata), .pf_addr(pf_addr),
    .q_full(q_full), .flush(flush), .q_push(q_push), .q_data(q_data), .ip_inc(ip_inc),
    .ale(ale), .addr_out(addr_out), .rd_n(rd_n), .wr_n(wr_n), .dout(dout),
    .dout_en(dout_en), .din(din), .ready(ready), .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        eu;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          waits;
    int          flush_at;
    int          exp_strobe;
    int          exp_den;
    int          exp_ack;
    int          exp_push;
    int          exp_err;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[11];

  // One isolated cycle from IDLE; waits = number of ready=0 samples before ready rises.
  task automatic run_vec(input vec_t v, input int idx);
    int j = 0, n_ale = 0, n_rd = 0, n_wr = 0, n_den = 0;
    int n_ack = 0, n_push = 0, n_ip = 0, n_err = 0;
    logic [7:0]  got_data = 8'h00, got_dout = 8'h00;
    logic [19:0] got_addr = '0;
    @(negedge clk);
    eu_req = v.eu; eu_wr = v.wr; eu_addr = v.addr; eu_wdata = v.wdata;
    pf_addr = v.addr; q_full = v.eu; flush = 1'b0; ready = 1'b0; din = v.din;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      q_full = 1'b1;
      if (!rd_n || !wr_n) j++;
      ready = (j >= 2 + v.waits);
      flush = (c == v.flush_at);
      #1;
      if (ale) begin n_ale++; got_addr = addr_out; end
      if (!rd_n) n_rd++;
      if (!wr_n) n_wr++;
      if (dout_en) begin n_den++; got_dout = dout; end
      if (eu_ack) begin n_ack++; got_data = eu_rdata; eu_req = 1'b0; end
      if (q_push) begin n_push++; got_data = q_data; end
      if (ip_inc) n_ip++;
      if (bus_err) n_err++;
    end
    flush = 1'b0;
    check($sformatf("v%0d_ale", idx), n_ale, 1);
    check($sformatf("v%0d_addr", idx), got_addr, v.addr);
    check($sformatf("v%0d_rd_clocks", idx), n_rd, v.wr ? 0 : v.exp_strobe);
    check($sformatf("v%0d_wr_clocks", idx), n_wr, v.wr ? v.exp_strobe : 0);
    check($sformatf("v%0d_dout_en_clocks", idx), n_den, v.exp_den);
    check($sformatf("v%0d_ack", idx), n_ack, v.exp_ack);
    check($sformatf("v%0d_push", idx), n_push, v.exp_push);
    check($sformatf("v%0d_ip_inc", idx), n_ip, v.exp_push);
    check($sformatf("v%0d_bus_err", idx), n_err, v.exp_err);
    if (v.wr) check($sformatf("v%0d_dout", idx), got_dout, v.wdata);
    else if (v.exp_ack + v.exp_push > 0) check($sformatf("v%0d_data", idx), got_data, v.exp_data);
  endtask

  // Transaction-level reference: position within the cycle counted in clocks since T1.
  logic        m_act, m_end, m_eu, m_wr, m_drop, m_to, prev_ack;
  int          m_pos;
  logic [19:0] m_addr;
  logic [7:0]  m_wdata, m_rdata, m_qdata;
  logic        e_ale, e_strb, e_den, e_ack, e_push, e_err;
  logic [7:0]  e_dout;

  logic [8:0]  ale_v, ack_v, push_v;
  logic [19:0] addr_c0, addr_c4;
  logic [7:0]  rdata_c3, qdata_c7;
  int          n_bad_evt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          eu    wr    addr       wdata  din    w   fl  strb den ack push err data
    vecs[0]  = '{1'b0, 1'b0, 20'h00400, 8'h00, 8'h90, 0,  -1, 2,  0,  0,  1,   0,  8'h90};
    vecs[1]  = '{1'b1, 1'b1, 20'h12345, 8'hA5, 8'h00, 2,  -1, 4,  5,  1,  0,   0,  8'h00};
    vecs[2]  = '{1'b1, 1'b0, 20'h0ABCD, 8'h00, 8'h3C, 0,  -1, 2,  0,  1,  0,   0,  8'h3C};
    vecs[3]  = '{1'b0, 1'b0, 20'h00401, 8'h00, 8'h11, 1,  2,  3,  0,  0,  0,   0,  8'h11};
    vecs[4]  = '{1'b0, 1'b0, 20'h00402, 8'h00, 8'h5A, 3,  -1, 5,  0,  0,  1,   0,  8'h5A};
    vecs[5]  = '{1'b1, 1'b0, 20'h7FFFF, 8'h00, 8'h22, 20, -1, 17, 0,  1,  0,   1,  8'hFF};
    vecs[6]  = '{1'b0, 1'b0, 20'h00403, 8'h00, 8'h33, 20, -1, 17, 0,  0,  1,   1,  8'hFF};
    vecs[7]  = '{1'b1, 1'b0, 20'h80000, 8'h00, 8'h77, 15, -1, 17, 0,  1,  0,   0,  8'h77};
    vecs[8]  = '{1'b0, 1'b0, 20'h00404, 8'h00, 8'h44, 0,  3,  2,  0,  0,  0,   0,  8'h44};
    vecs[9]  = '{1'b0, 1'b0, 20'h00405, 8'h00, 8'h55, 0,  0,  2,  0,  0,  0,   0,  8'h55};
    vecs[10] = '{1'b1, 1'b1, 20'hFFFFF, 8'h5C, 8'h00, 16, -1, 17, 18, 1,  0,   1,  8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {ale, rd_n, wr_n, dout_en, eu_ack, q_push, ip_inc, bus_err}, 8'b0110_0000);
    check("reset_addr", addr_out, 20'h0);
    check("reset_data", {dout, eu_rdata, q_data}, 24'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of T2 of a read aborts the cycle without ack or push.
    @(negedge clk);
    eu_req = 1'b1; eu_wr = 1'b0; eu_addr = 20'h0F0F0; ready = 1'b1; din = 8'hAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midreset_pre_rd_n", rd_n, 1'b0);
    rst = 1'b0; eu_req = 1'b0;
    #1;
    check("midreset_ctrl", {ale, rd_n, wr_n, dout_en, eu_ack, q_push, bus_err}, 7'b0110000);
    @(negedge clk);
    rst = 1'b1;
    n_bad_evt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ale || !rd_n || eu_ack || q_push) n_bad_evt++;
    end
    check("midreset_stays_idle", n_bad_evt, 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // EU has priority over a pending prefetch; prefetches then run back to back.
    @(negedge clk);
    eu_req = 1'b1; eu_wr = 1'b0; eu_addr = 20'h0BEEF; pf_addr = 20'h00100;
    q_full = 1'b0; ready = 1'b1; din = 8'hC3; flush = 1'b0;
    ale_v = '0; ack_v = '0; push_v = '0;
    addr_c0 = '0; addr_c4 = '0; rdata_c3 = '0; qdata_c7 = '0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      ale_v[c] = ale; ack_v[c] = eu_ack; push_v[c] = q_push;
      if (c == 0) addr_c0 = addr_out;
      if (c == 4) addr_c4 = addr_out;
      if (c == 3) rdata_c3 = eu_rdata;
      if (c == 7) qdata_c7 = q_data;
      if (eu_ack) eu_req = 1'b0;
    end
    q_full = 1'b1;
    check("prio_ale_pattern", ale_v, 9'b1_0001_0001);
    check("prio_ack_pattern", ack_v, 9'b0_0000_1000);
    check("prio_push_pattern", push_v, 9'b0_1000_0000);
    check("prio_eu_addr", addr_c0, 20'h0BEEF);
    check("prio_pf_addr", addr_c4, 20'h00100);
    check("prio_eu_rdata", rdata_c3, 8'hC3);
    check("prio_q_data", qdata_c7, 8'hC3);
    repeat (6) @(posedge clk);

    // A held flush keeps the sequencer from starting prefetches.
    @(negedge clk);
    q_full = 1'b0; flush = 1'b1;
    n_bad_evt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ale) n_bad_evt++;
    end
    check("flush_blocks_prefetch", n_bad_evt, 0);
    flush = 1'b0;
    @(posedge clk); #1;
    check("flush_release_starts_t1", ale, 1'b1);
    q_full = 1'b1;
    repeat (8) @(posedge clk);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b0; eu_req = 1'b0; q_full = 1'b1; flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_act = 0; m_end = 0; m_eu = 0; m_wr = 0; m_drop = 0; m_to = 0; m_pos = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_qdata = '0; prev_ack = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (eu_req && prev_ack) eu_req = 1'b0;
      else if (!eu_req && ($urandom_range(2) == 0)) begin
        eu_req = 1'b1; eu_wr = 1'($urandom_range(1));
        eu_addr = 20'($urandom); eu_wdata = 8'($urandom);
      end
      q_full  = ($urandom_range(3) == 0);
      flush   = ($urandom_range(9) == 0);
      ready   = ((i % 200) >= 170) ? 1'b0 : ($urandom_range(9) >= 3);
      din     = 8'($urandom);
      pf_addr = 20'($urandom);
      #1;
      e_ale  = m_act && !m_end && (m_pos == 0);
      e_strb = m_act && !m_end && (m_pos >= 1);
      e_den  = m_act && m_wr && (m_pos >= 1);
      e_ack  = m_end && m_eu;
      e_push = m_end && !m_eu && !m_wr && !m_drop && !flush;
      e_err  = m_end && m_to;
      e_dout = e_den ? m_wdata : 8'h00;
      check($sformatf("rand_clk%0d", i),
            {ale, rd_n, wr_n, dout_en, eu_ack, q_push, ip_inc, bus_err, addr_out, dout, eu_rdata, q_data},
            {e_ale, !(e_strb && !m_wr), !(e_strb && m_wr), e_den, e_ack, e_push, e_push, e_err,
             m_addr, e_dout, m_rdata, m_qdata});
      prev_ack = e_ack;
      if (!m_act || m_end) begin
        m_end = 0; m_pos = 0; m_drop = 0; m_to = 0;
        if (eu_req && !(e_ack)) begin
          m_act = 1; m_eu = 1; m_wr = eu_wr; m_addr = eu_addr; m_wdata = eu_wdata;
        end else if (!q_full && !flush) begin
          m_act = 1; m_eu = 0; m_wr = 0; m_addr = pf_addr;
        end else begin
          m_act = 0;
        end
      end else begin
        m_drop = m_drop | flush;
        if (m_pos < 2) m_pos++;
        else if (ready || (m_pos - 2 == WAIT_MAX)) begin
          m_end = 1;
          m_to  = !ready;
          if (!m_wr) begin
            if (m_eu) m_rdata = ready ? din : 8'hFF;
            else      m_qdata = ready ? din : 8'hFF;
          end
        end else m_pos++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
